// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MIPS-style HI/LO multiply/divide unit (one bit per cycle)
//   Clk, Reset                async active-high reset
//   Start_EX, Op_EX           issue request; 000 MULT 001 MULTU 010 DIV 011 DIVU 100 MTHI 101 MTLO
//   Rs_Data_EX, Rt_Data_EX    operands (MTHI/MTLO source is Rs)
//   Flush_EX                  abort in-flight operation, drops a same-cycle request
//   HI_EX, LO_EX              architectural HI/LO registers
//   Busy_EX, Done_EX          in-flight flag, one-cycle result-written pulse
//   Stall_EX                  Start_EX & Busy_EX
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start_EX,
  input  logic [2:0]       Op_EX,
  input  logic [WIDTH-1:0] Rs_Data_EX,
  input  logic [WIDTH-1:0] Rt_Data_EX,
  input  logic             Flush_EX,
  output logic [WIDTH-1:0] HI_EX,
  output logic [WIDTH-1:0] LO_EX,
  output logic             Busy_EX,
  output logic             Done_EX,
  output logic             Stall_EX
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_acc_hi, r_acc_lo, r_op;
  logic r_div, r_neg_q, r_neg_r, r_dz, r_done;
  logic w_idle_req, w_accept, w_mt, w_sa, w_sb, w_ge;
  logic [WIDTH-1:0] w_mag_a, w_mag_b, w_quo, w_rem;
  logic [WIDTH:0] w_madd, w_dsh, w_ddiff;
  logic [2*WIDTH-1:0] w_mnext, w_dnext, w_prod, w_prod_s;
  assign w_idle_req = r_state == IDLE && Start_EX && !Flush_EX;
  assign w_accept = w_idle_req && !Op_EX[2];
  assign w_mt = w_idle_req && Op_EX[2:1] == 2'b10;
  assign w_sa = !Op_EX[0] && Rs_Data_EX[WIDTH-1];
  assign w_sb = !Op_EX[0] && Rt_Data_EX[WIDTH-1];
  assign w_mag_a = w_sa ? -Rs_Data_EX : Rs_Data_EX;
  assign w_mag_b = w_sb ? -Rt_Data_EX : Rt_Data_EX;
  // Multiply: multiplier sits in r_acc_lo and shifts out LSB-first while the product fills in from the top.
  assign w_madd = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_op} : '0);
  assign w_mnext = {w_madd, r_acc_lo[WIDTH-1:1]};
  // Divide: dividend shifts out of r_acc_lo MSB-first into the partial remainder; quotient bits shift in.
  // The partial remainder stays below the divisor, so the shifted value fits WIDTH+1 bits and
  // the difference's top bit is a clean borrow.
  assign w_dsh = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_ddiff = w_dsh - {1'b0, r_op};
  assign w_ge = !w_ddiff[WIDTH];
  assign w_dnext = {w_ge ? w_ddiff[WIDTH-1:0] : w_dsh[WIDTH-1:0], r_acc_lo[WIDTH-2:0], w_ge};
  assign w_prod = {r_acc_hi, r_acc_lo};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  // With a zero divisor the remainder path returns |Rs|, which sign-corrects back to Rs itself.
  assign w_quo = r_dz ? '1 : r_neg_q ? -r_acc_lo : r_acc_lo;
  assign w_rem = r_neg_r ? -r_acc_hi : r_acc_hi;
  always_comb begin
    w_next = r_state;
    if (Flush_EX) w_next = IDLE;
    else if (r_state == IDLE) w_next = w_accept ? RUN : IDLE;
    else if (r_state == RUN) w_next = r_cnt == CW'(1) ? FIX : RUN;
    else w_next = IDLE;
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_op <= '0;
      r_div <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= r_state == FIX && !Flush_EX;
      if (w_accept) begin
        r_div <= Op_EX[1];
        r_neg_q <= w_sa ^ w_sb;
        r_neg_r <= w_sa;
        r_dz <= Op_EX[1] && Rt_Data_EX == '0;
        r_op <= Op_EX[1] ? w_mag_b : w_mag_a;
        r_acc_hi <= '0;
        r_acc_lo <= Op_EX[1] ? w_mag_a : w_mag_b;
        r_cnt <= CW'(WIDTH);
      end else if (r_state == RUN && !Flush_EX) begin
        r_cnt <= r_cnt - CW'(1);
        {r_acc_hi, r_acc_lo} <= r_div ? w_dnext : w_mnext;
      end
      if (r_state == FIX && !Flush_EX) {r_hi, r_lo} <= r_div ? {w_rem, w_quo} : w_prod_s;
      if (w_mt && Op_EX[0]) r_lo <= Rs_Data_EX;
      if (w_mt && !Op_EX[0]) r_hi <= Rs_Data_EX;
    end
  end
  assign HI_EX = r_hi;
  assign LO_EX = r_lo;
  assign Busy_EX = r_state != IDLE;
  assign Done_EX = r_done;
  assign Stall_EX = Start_EX && Busy_EX;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: randomized + directed check of ex_muldiv_unit against a cycle-count arithmetic model
module tb_ex_muldiv_unit;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] rs = '0, rt = '0;
  logic [31:0] hi, lo;
  logic busy, done, stall;
  int total = 0, bad = 0;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  logic m_busy, m_done;
  int m_left;
  ex_muldiv_unit #(.WIDTH(32)) dut (
    .Clk(clk), .Reset(rst), .Start_EX(start), .Op_EX(op), .Rs_Data_EX(rs), .Rt_Data_EX(rt),
    .Flush_EX(flush), .HI_EX(hi), .LO_EX(lo), .Busy_EX(busy), .Done_EX(done), .Stall_EX(stall)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int sa, sb;
    sa = a;
    sb = b;
    if (o == 3'd0) begin
      p = longint'(sa) * longint'(sb);
      return p;
    end
    if (o == 3'd1) return 64'(a) * 64'(b);
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (o == 3'd2) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi <= '0;
      m_lo <= '0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      m_res <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (flush) m_busy <= 1'b0;
        else if (m_left == 1) begin
          m_hi <= m_res[63:32];
          m_lo <= m_res[31:0];
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end else m_left <= m_left - 1;
      end else if (start && !flush) begin
        if (!op[2]) begin
          m_res <= ref_res(op, rs, rt);
          m_busy <= 1'b1;
          m_left <= 33;
        end else if (op == 3'd4) m_hi <= rs;
        else if (op == 3'd5) m_lo <= rs;
      end
    end
  end
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("hi", {32'h0, hi}, {32'h0, m_hi});
      chk("lo", {32'h0, lo}, {32'h0, m_lo});
      chk("busy", {63'h0, busy}, {63'h0, m_busy});
      chk("done", {63'h0, done}, {63'h0, m_done});
      chk("stall", {63'h0, stall}, {63'h0, start & m_busy});
    end
  end
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op = o;
    rs = a;
    rt = b;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #2;
      seen = done;
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    #12;
    chk("reset_hi", {32'h0, hi}, 64'h0);
    chk("reset_lo", {32'h0, lo}, 64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    chk("model_mult", ref_res(3'd0, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
    chk("model_div", ref_res(3'd2, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("model_divmin", ref_res(3'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    wait_done();
    chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    @(posedge clk);
    #2;
    chk("done_one_cycle", {63'h0, done}, 64'h0);
    issue(3'd3, 32'd100, 32'd7);
    wait_done();
    chk("divu_hilo", {hi, lo}, {32'd2, 32'd14});
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done();
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(3'd2, 32'h1234_5678, 32'd0);
    wait_done();
    chk("div_zero", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
    issue(3'd2, 32'hFFFF_FFF9, 32'd0);
    wait_done();
    chk("div_zero_neg", {hi, lo}, 64'hFFFF_FFF9_FFFF_FFFF);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    chk("div_wrap", {hi, lo}, 64'h0000_0000_8000_0000);
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    repeat (3) @(negedge clk);
    start = 1'b1;
    op = 3'd3;
    rs = 32'd50;
    rt = 32'd3;
    #1;
    chk("stall_busy", {63'h0, stall}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("mult_after_stall", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    issue(3'd0, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #2;
    chk("flush_busy", {63'h0, busy}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    repeat (40) @(negedge clk);
    chk("flush_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);
    start = 1'b1;
    op = 3'd5;
    rs = 32'hA5A5_A5A5;
    @(posedge clk);
    #2;
    chk("mtlo", {32'h0, lo}, 64'hA5A5_A5A5);
    chk("mtlo_busy", {63'h0, busy}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    issue(3'd2, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_hilo", {hi, lo}, 64'h0);
    chk("rst_busy_done", {62'h0, busy, done}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = $urandom_range(0, 3) == 0;
      op = 3'($urandom_range(0, 7));
      rs = pick();
      rt = pick();
      flush = $urandom_range(0, 60) == 0;
    end
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    repeat (40) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
